// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types, defaults and sizing helpers for the bus interconnect
package bus_pkg;

   localparam int DWidthDef        = 32;
   localparam int NumofSlaveDef    = 4;
   localparam int RegionShiftDef   = 28;
   localparam int TimeoutCyclesDef = 255;

   localparam int IdxW = DWidthDef - RegionShiftDef;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      ERR1 = 2'd2,
      ERR2 = 2'd3
   } state_t;

   typedef enum logic {
      CAUSE_UNMAPPED = 1'b0,
      CAUSE_TIMEOUT  = 1'b1
   } err_cause_t;

   // A disabled watchdog (0 cycles) still needs a 1-bit counter to keep widths legal.
   function automatic int cnt_width(input int timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

   localparam int CntW = cnt_width(TimeoutCyclesDef);

endpackage

// File: rtl/bus_addr_decoder.sv
// rtl/bus_addr_decoder.sv - region index to one-hot slave select and mapped flag
module bus_addr_decoder
   import bus_pkg::*;
#(
   parameter int DWidth      = DWidthDef,
   parameter int NumofSlave  = NumofSlaveDef,
   parameter int RegionShift = RegionShiftDef
) (
   input  logic [DWidth-RegionShift-1:0] idx_i,
   output logic [NumofSlave-1:0]         sel_o,
   output logic                          mapped_o
);

   localparam int RegIdxW = DWidth - RegionShift;
   // One extra bit so NumofSlave == 2^RegIdxW still compares correctly.
   localparam logic [RegIdxW:0] NumSlv = (RegIdxW+1)'(NumofSlave);

   assign mapped_o = ({1'b0, idx_i} < NumSlv);

   always_comb begin
      sel_o = '0;
      for (int i = 0; i < NumofSlave; i++) begin
         if (idx_i == RegIdxW'(i)) begin
            sel_o[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_interconnect.sv
// rtl/bus_interconnect.sv - single-master N-slave interconnect with default slave,
// data-phase watchdog and first-error log.
module bus_interconnect
   import bus_pkg::*;
#(
   parameter int DWidth        = DWidthDef,
   parameter int NumofSlave    = NumofSlaveDef,
   parameter int RegionShift   = RegionShiftDef,
   parameter int TimeoutCycles = TimeoutCyclesDef
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [DWidth-1:0]                addr_i,
   input  logic                             trans_i,
   input  logic [NumofSlave-1:0][DWidth-1:0] rdata_i,
   input  logic [NumofSlave-1:0]            resp_i,
   input  logic [NumofSlave-1:0]            readyout_i,
   output logic [NumofSlave-1:0]            sel_o,
   output logic [NumofSlave-1:0]            abort_o,
   output logic [DWidth-1:0]                rdata_o,
   output logic                             resp_o,
   output logic                             ready_o,
   output logic                             err_valid_o,
   output logic [DWidth-1:0]                err_addr_o,
   output logic                             err_cause_o,
   input  logic                             err_clear_i
);

   localparam int               WdCntW  = cnt_width(TimeoutCycles);
   localparam bit               WdEn    = (TimeoutCycles > 0);
   localparam logic [WdCntW-1:0] CntLast = WdCntW'(TimeoutCycles - 1);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [NumofSlave-1:0]   r_dsel;
   logic [DWidth-1:0]       r_daddr;
   logic [WdCntW-1:0]       r_cnt;
   logic                    r_err_valid;
   logic [DWidth-1:0]       r_err_addr;
   err_cause_t              r_err_cause;

   logic [NumofSlave-1:0]   w_sel;
   logic                    w_mapped;
   logic                    w_accept;
   logic                    w_slv_ready;
   logic                    w_slv_resp;
   logic [DWidth-1:0]       w_slv_rdata;
   logic                    w_timeout;
   logic                    w_capture;
   logic [DWidth-1:0]       w_cap_addr;
   err_cause_t              w_cap_cause;

   bus_addr_decoder #(
      .DWidth      (DWidth),
      .NumofSlave  (NumofSlave),
      .RegionShift (RegionShift)
   ) u_dec (
      .idx_i    (addr_i[DWidth-1:RegionShift]),
      .sel_o    (w_sel),
      .mapped_o (w_mapped)
   );

   assign sel_o = w_sel;

   // dsel is one-hot, so an AND-OR mux picks the active slave without an index.
   always_comb begin
      w_slv_rdata = '0;
      for (int i = 0; i < NumofSlave; i++) begin
         if (r_dsel[i]) begin
            w_slv_rdata = w_slv_rdata | rdata_i[i];
         end
      end
   end

   assign w_slv_ready = |(readyout_i & r_dsel);
   assign w_slv_resp  = |(resp_i & r_dsel);
   assign w_timeout   = WdEn && (r_state == DATA) && !w_slv_ready && (r_cnt == CntLast);
   assign w_accept    = trans_i && ready_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      ready_o     = 1'b0;
      resp_o      = 1'b0;
      rdata_o     = '0;
      abort_o     = '0;
      unique case (r_state)
         IDLE: begin
            ready_o = 1'b1;
            if (trans_i) begin
               w_state_nxt = w_mapped ? DATA : ERR1;
            end
         end
         DATA: begin
            ready_o = w_slv_ready;
            resp_o  = w_slv_resp;
            rdata_o = w_slv_rdata;
            if (w_slv_ready) begin
               if (trans_i) begin
                  w_state_nxt = w_mapped ? DATA : ERR1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else if (w_timeout) begin
               w_state_nxt = ERR1;
               abort_o     = r_dsel;
            end
         end
         ERR1: begin
            resp_o      = 1'b1;
            w_state_nxt = ERR2;
         end
         ERR2: begin
            ready_o = 1'b1;
            resp_o  = 1'b1;
            if (trans_i) begin
               w_state_nxt = w_mapped ? DATA : ERR1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_dsel  <= '0;
         r_daddr <= '0;
      end else if (w_accept) begin
         r_dsel  <= w_sel;
         r_daddr <= addr_i;
      end
   end

   // Every entry into DATA comes from a ready cycle, so clearing on ready covers both cases.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if ((r_state == DATA) && !w_slv_ready) begin
         if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end else begin
         r_cnt <= '0;
      end
   end

   // An unmapped error's address is the phase being accepted right now.
   assign w_cap_addr  = w_timeout ? r_daddr : addr_i;
   assign w_cap_cause = w_timeout ? CAUSE_TIMEOUT : CAUSE_UNMAPPED;
   assign w_capture   = (w_state_nxt == ERR1) && (!r_err_valid || err_clear_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_err_valid <= 1'b0;
         r_err_addr  <= '0;
         r_err_cause <= CAUSE_UNMAPPED;
      end else if (w_capture) begin
         r_err_valid <= 1'b1;
         r_err_addr  <= w_cap_addr;
         r_err_cause <= w_cap_cause;
      end else if (err_clear_i) begin
         r_err_valid <= 1'b0;
         r_err_addr  <= '0;
         r_err_cause <= CAUSE_UNMAPPED;
      end
   end

   assign err_valid_o = r_err_valid;
   assign err_addr_o  = r_err_addr;
   assign err_cause_o = r_err_cause;

endmodule

// File: tb/tb_bus_interconnect.sv
// tb/tb_bus_interconnect.sv - directed self-checking bench for bus_interconnect
module tb_bus_interconnect;

   localparam int DW = 32;
   localparam int NS = 4;

   logic                   clk_i = 1'b0;
   logic                   rst_ni = 1'b0;
   logic [DW-1:0]          addr_i;
   logic                   trans_i;
   logic [NS-1:0][DW-1:0]  rdata_i;
   logic [NS-1:0]          resp_i;
   logic [NS-1:0]          readyout_i;
   logic [NS-1:0]          sel_o;
   logic [NS-1:0]          abort_o;
   logic [DW-1:0]          rdata_o;
   logic                   resp_o;
   logic                   ready_o;
   logic                   err_valid_o;
   logic [DW-1:0]          err_addr_o;
   logic                   err_cause_o;
   logic                   err_clear_i;

   int n_cmp = 0;
   int n_mis = 0;

   bus_interconnect #(
      .DWidth        (DW),
      .NumofSlave    (NS),
      .RegionShift   (28),
      .TimeoutCycles (8)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .addr_i      (addr_i),
      .trans_i     (trans_i),
      .rdata_i     (rdata_i),
      .resp_i      (resp_i),
      .readyout_i  (readyout_i),
      .sel_o       (sel_o),
      .abort_o     (abort_o),
      .rdata_o     (rdata_o),
      .resp_o      (resp_o),
      .ready_o     (ready_o),
      .err_valid_o (err_valid_o),
      .err_addr_o  (err_addr_o),
      .err_cause_o (err_cause_o),
      .err_clear_i (err_clear_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic sample();
      @(negedge clk_i);
   endtask

   initial begin
      addr_i      = '0;
      trans_i     = 1'b0;
      err_clear_i = 1'b0;
      resp_i      = '0;
      readyout_i  = '1;
      rdata_i[0]  = 32'h0000_A000;
      rdata_i[1]  = 32'hDEAD_BEEF;
      rdata_i[2]  = 32'h2222_2222;
      rdata_i[3]  = 32'h3333_3333;

      #3;
      check_eq("rst_ready", 64'(ready_o), 64'h1);
      check_eq("rst_resp", 64'(resp_o), 64'h0);
      check_eq("rst_rdata", 64'(rdata_o), 64'h0);
      check_eq("rst_abort", 64'(abort_o), 64'h0);
      check_eq("rst_err_valid", 64'(err_valid_o), 64'h0);
      check_eq("rst_err_addr", 64'(err_addr_o), 64'h0);
      check_eq("rst_err_cause", 64'(err_cause_o), 64'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      next_cycle();

      // Single read from slave 1
      addr_i  = 32'h1000_0040;
      trans_i = 1'b1;
      sample();
      check_eq("rd_sel", 64'(sel_o), 64'h2);
      check_eq("rd_addr_ready", 64'(ready_o), 64'h1);
      next_cycle();
      trans_i = 1'b0;
      addr_i  = '0;
      sample();
      check_eq("rd_rdata", 64'(rdata_o), 64'hDEAD_BEEF);
      check_eq("rd_ready", 64'(ready_o), 64'h1);
      check_eq("rd_resp", 64'(resp_o), 64'h0);
      next_cycle();

      // Unmapped access goes to the default slave
      addr_i  = 32'h5000_0000;
      trans_i = 1'b1;
      sample();
      check_eq("um_sel", 64'(sel_o), 64'h0);
      next_cycle();
      trans_i = 1'b0;
      addr_i  = '0;
      sample();
      check_eq("um_err1_ready", 64'(ready_o), 64'h0);
      check_eq("um_err1_resp", 64'(resp_o), 64'h1);
      check_eq("um_err1_rdata", 64'(rdata_o), 64'h0);
      check_eq("um_err_valid", 64'(err_valid_o), 64'h1);
      check_eq("um_err_addr", 64'(err_addr_o), 64'h5000_0000);
      check_eq("um_err_cause", 64'(err_cause_o), 64'h0);
      next_cycle();
      sample();
      check_eq("um_err2_ready", 64'(ready_o), 64'h1);
      check_eq("um_err2_resp", 64'(resp_o), 64'h1);
      next_cycle();
      sample();
      check_eq("um_idle_ready", 64'(ready_o), 64'h1);
      check_eq("um_idle_resp", 64'(resp_o), 64'h0);

      // Back-to-back slave 0 then slave 3, no bubble
      addr_i  = 32'h0000_0100;
      trans_i = 1'b1;
      sample();
      check_eq("b2b_sel0", 64'(sel_o), 64'h1);
      next_cycle();
      addr_i = 32'h3000_0200;
      sample();
      check_eq("b2b_sel3", 64'(sel_o), 64'h8);
      check_eq("b2b_ready0", 64'(ready_o), 64'h1);
      check_eq("b2b_rdata0", 64'(rdata_o), 64'h0000_A000);
      next_cycle();
      trans_i = 1'b0;
      addr_i  = '0;
      resp_i  = 4'b1000;
      sample();
      check_eq("b2b_rdata3", 64'(rdata_o), 64'h3333_3333);
      check_eq("b2b_ready3", 64'(ready_o), 64'h1);
      check_eq("b2b_resp3", 64'(resp_o), 64'h1);
      next_cycle();
      resp_i      = '0;
      err_clear_i = 1'b1;
      next_cycle();
      err_clear_i = 1'b0;
      sample();
      check_eq("clr_valid", 64'(err_valid_o), 64'h0);
      check_eq("clr_addr", 64'(err_addr_o), 64'h0);

      // Watchdog: slave 2 stalls
      readyout_i = 4'b1011;
      addr_i     = 32'h2000_0000;
      trans_i    = 1'b1;
      next_cycle();
      trans_i = 1'b0;
      addr_i  = '0;
      for (int k = 1; k <= 8; k++) begin
         sample();
         check_eq($sformatf("wd_ready_%0d", k), 64'(ready_o), 64'h0);
         check_eq($sformatf("wd_resp_%0d", k), 64'(resp_o), 64'h0);
         check_eq($sformatf("wd_abort_%0d", k), 64'(abort_o), (k == 8) ? 64'h4 : 64'h0);
         next_cycle();
      end
      sample();
      check_eq("wd_err1_ready", 64'(ready_o), 64'h0);
      check_eq("wd_err1_resp", 64'(resp_o), 64'h1);
      check_eq("wd_err1_abort", 64'(abort_o), 64'h0);
      check_eq("wd_err_valid", 64'(err_valid_o), 64'h1);
      check_eq("wd_err_addr", 64'(err_addr_o), 64'h2000_0000);
      check_eq("wd_err_cause", 64'(err_cause_o), 64'h1);
      next_cycle();
      sample();
      check_eq("wd_err2_ready", 64'(ready_o), 64'h1);
      check_eq("wd_err2_resp", 64'(resp_o), 64'h1);
      readyout_i = '1;
      next_cycle();

      // Clear colliding with a new capture: the capture wins
      addr_i      = 32'h6000_0010;
      trans_i     = 1'b1;
      err_clear_i = 1'b1;
      next_cycle();
      trans_i     = 1'b0;
      err_clear_i = 1'b0;
      addr_i      = '0;
      sample();
      check_eq("cc_valid", 64'(err_valid_o), 64'h1);
      check_eq("cc_addr", 64'(err_addr_o), 64'h6000_0010);
      check_eq("cc_cause", 64'(err_cause_o), 64'h0);
      next_cycle();
      next_cycle();

      // A second error while the log is held is dropped
      addr_i  = 32'h7000_0000;
      trans_i = 1'b1;
      next_cycle();
      trans_i = 1'b0;
      addr_i  = '0;
      sample();
      check_eq("drop_resp", 64'(resp_o), 64'h1);
      check_eq("drop_addr", 64'(err_addr_o), 64'h6000_0010);
      next_cycle();
      next_cycle();

      // Asynchronous reset during ERR1
      addr_i  = 32'hF000_0000;
      trans_i = 1'b1;
      next_cycle();
      trans_i = 1'b0;
      addr_i  = '0;
      check_eq("ar_pre_resp", 64'(resp_o), 64'h1);
      #2;
      rst_ni = 1'b0;
      #1;
      check_eq("ar_ready", 64'(ready_o), 64'h1);
      check_eq("ar_resp", 64'(resp_o), 64'h0);
      check_eq("ar_rdata", 64'(rdata_o), 64'h0);
      check_eq("ar_abort", 64'(abort_o), 64'h0);
      check_eq("ar_err_valid", 64'(err_valid_o), 64'h0);
      check_eq("ar_err_addr", 64'(err_addr_o), 64'h0);
      check_eq("ar_err_cause", 64'(err_cause_o), 64'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      next_cycle();
      sample();
      check_eq("post_rst_ready", 64'(ready_o), 64'h1);
      check_eq("post_rst_resp", 64'(resp_o), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
